// File: rtl/twopole_cascade.sv
// twopole_cascade: six-section cascade of two-pole resonators (speech synthesis filter).
// Each section computes acc = x + b1*y1 + b2*y2 using an external shared multiplier,
// driven over a start/done handshake, then shifts its history and passes acc onwards.
//
// Ports:
//   clk, rst_an          clock, asynchronous active-low reset
//   sample_in/_valid     excitation sample input, accepted while ready=1
//   ready                high only when idle
//   coef_wr/addr/data    coefficient file write (addr 2s = b1[s], 2s+1 = b2[s]; 256 = 1.0)
//   state_clr            synchronous history clear and abort of the current sample
//   mul_sig/mul_coef     registered multiplier operands
//   mul_start/mul_done   multiplier handshake; mul_result = (sig*coef)>>>8
//   sample_out/_valid    registered filtered sample, one-cycle valid pulse
//
// Build option: define TWOPOLE_SAT_EN to clamp each sum to 16-bit signed range;
// otherwise sums wrap modulo 2^16.

module twopole_cascade #(
    parameter int unsigned NSEC = 6
) (
    input  logic        clk,
    input  logic        rst_an,
    input  logic [15:0] sample_in,
    input  logic        sample_valid,
    output logic        ready,
    input  logic        coef_wr,
    input  logic [3:0]  coef_addr,
    input  logic [9:0]  coef_data,
    input  logic        state_clr,
    output logic [15:0] mul_sig,
    output logic [9:0]  mul_coef,
    output logic        mul_start,
    input  logic        mul_done,
    input  logic [15:0] mul_result,
    output logic [15:0] sample_out,
    output logic        sample_out_valid
);

    localparam int unsigned NCOEF = 2 * NSEC;
    localparam logic [2:0] LAST_SEC = 3'(NSEC - 1);

    typedef enum logic [2:0] {
        StIdle, StIssue1, StWait1, StIssue2, StWait2, StUpdate, StOutput, StDrain
    } state_e;

    state_e      state_q, state_d;
    logic [2:0]  sec_q, sec_d;
    logic [15:0] acc_q, acc_d;
    logic        busy_q, busy_d;
    logic [15:0] mul_sig_q;
    logic [9:0]  mul_coef_q;
    logic [15:0] sample_out_q;
    logic [9:0]  coef_q [NCOEF];
    logic [15:0] y1_q [NSEC];
    logic [15:0] y2_q [NSEC];

    logic [16:0] sum17;
    logic [15:0] sum16;

    assign sum17 = {acc_q[15], acc_q} + {mul_result[15], mul_result};

`ifdef TWOPOLE_SAT_EN
    // Overflow when the two top bits of the 17-bit sum disagree; clamp toward the sign.
    always_comb begin
        sum16 = sum17[15:0];
        if (sum17[16] != sum17[15]) begin
            sum16 = sum17[16] ? 16'h8000 : 16'h7fff;
        end
    end
`else
    assign sum16 = sum17[15:0];
`endif

    // No request is raised in the cycle a clear arrives.
    assign mul_start        = ((state_q == StIssue1) || (state_q == StIssue2)) && !state_clr;
    assign ready            = (state_q == StIdle);
    assign sample_out_valid = (state_q == StOutput) && !state_clr;
    assign mul_sig          = mul_sig_q;
    assign mul_coef         = mul_coef_q;
    assign sample_out       = sample_out_q;

    always_comb begin
        state_d = state_q;
        sec_d   = sec_q;
        acc_d   = acc_q;
        busy_d  = busy_q;
        if (mul_start) begin
            busy_d = 1'b1;
        end
        if (mul_done && busy_q) begin
            busy_d = 1'b0;
        end
        if (state_clr) begin
            // An outstanding product must be absorbed before a new sample can start.
            state_d = (busy_q && !mul_done) ? StDrain : StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (sample_valid) begin
                        acc_d   = sample_in;
                        sec_d   = 3'd0;
                        state_d = StIssue1;
                    end
                end
                StIssue1: state_d = StWait1;
                StWait1: begin
                    if (mul_done) begin
                        acc_d   = sum16;
                        state_d = StIssue2;
                    end
                end
                StIssue2: state_d = StWait2;
                StWait2: begin
                    if (mul_done) begin
                        acc_d   = sum16;
                        state_d = StUpdate;
                    end
                end
                StUpdate: begin
                    if (sec_q == LAST_SEC) begin
                        state_d = StOutput;
                    end else begin
                        sec_d   = sec_q + 3'd1;
                        state_d = StIssue1;
                    end
                end
                StOutput: state_d = StIdle;
                StDrain: begin
                    if (mul_done) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_an) begin
        if (!rst_an) begin
            state_q      <= StIdle;
            sec_q        <= 3'd0;
            acc_q        <= 16'd0;
            busy_q       <= 1'b0;
            mul_sig_q    <= 16'd0;
            mul_coef_q   <= 10'd0;
            sample_out_q <= 16'd0;
        end else begin
            state_q <= state_d;
            sec_q   <= sec_d;
            acc_q   <= acc_d;
            busy_q  <= busy_d;
            // Operands are captured on entry to an ISSUE state so they are valid with
            // mul_start and hold until the next issue; a coefficient written during the
            // issue cycle therefore does not affect that multiply.
            if (state_d == StIssue1) begin
                mul_sig_q  <= y1_q[sec_d];
                mul_coef_q <= coef_q[{sec_d, 1'b0}];
            end else if (state_d == StIssue2) begin
                mul_sig_q  <= y2_q[sec_q];
                mul_coef_q <= coef_q[{sec_q, 1'b1}];
            end
            if ((state_q == StUpdate) && (state_d == StOutput)) begin
                sample_out_q <= acc_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_an) begin
        if (!rst_an) begin
            for (int unsigned i = 0; i < NCOEF; i++) begin
                coef_q[i] <= 10'd0;
            end
        end else if (coef_wr && (coef_addr < 4'(NCOEF))) begin
            coef_q[coef_addr] <= coef_data;
        end
    end

    always_ff @(posedge clk or negedge rst_an) begin
        if (!rst_an) begin
            for (int unsigned i = 0; i < NSEC; i++) begin
                y1_q[i] <= 16'd0;
                y2_q[i] <= 16'd0;
            end
        end else if (state_clr) begin
            for (int unsigned i = 0; i < NSEC; i++) begin
                y1_q[i] <= 16'd0;
                y2_q[i] <= 16'd0;
            end
        end else if (state_q == StUpdate) begin
            y2_q[sec_q] <= y1_q[sec_q];
            y1_q[sec_q] <= acc_q;
        end
    end

endmodule

// File: tb/tb_twopole_cascade.sv
// Self-checking bench for twopole_cascade: directed cases plus randomized samples and
// coefficients compared against a plain-arithmetic filter model; a multiplier model
// answers the start/done handshake with a configurable latency.
module tb_twopole_cascade;

    logic        clk = 1'b0;
    logic        rst_an;
    logic [15:0] sample_in;
    logic        sample_valid;
    logic        ready;
    logic        coef_wr;
    logic [3:0]  coef_addr;
    logic [9:0]  coef_data;
    logic        state_clr;
    logic [15:0] mul_sig;
    logic [9:0]  mul_coef;
    logic        mul_start;
    logic        mul_done = 1'b0;
    logic [15:0] mul_result = 16'd0;
    logic [15:0] sample_out;
    logic        sample_out_valid;

    int total = 0;
    int bad   = 0;

    twopole_cascade dut (
        .clk              (clk),
        .rst_an           (rst_an),
        .sample_in        (sample_in),
        .sample_valid     (sample_valid),
        .ready            (ready),
        .coef_wr          (coef_wr),
        .coef_addr        (coef_addr),
        .coef_data        (coef_data),
        .state_clr        (state_clr),
        .mul_sig          (mul_sig),
        .mul_coef         (mul_coef),
        .mul_start        (mul_start),
        .mul_done         (mul_done),
        .mul_result       (mul_result),
        .sample_out       (sample_out),
        .sample_out_valid (sample_out_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint got, input longint exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // ---------------- reference arithmetic ----------------
    function automatic logic signed [15:0] mulq(input logic signed [15:0] a,
                                                input logic signed [9:0] c);
        int p;
        p = a * c;
        return 16'(p >>> 8);
    endfunction

    function automatic logic signed [15:0] add16(input logic signed [15:0] a,
                                                 input logic signed [15:0] b);
        int s;
        s = int'(a) + int'(b);
`ifdef TWOPOLE_SAT_EN
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
`endif
        return 16'(s);
    endfunction

    logic signed [15:0] my1 [6];
    logic signed [15:0] my2 [6];
    logic signed [9:0]  mcoef [12];

    function automatic logic signed [15:0] model_step(input logic signed [15:0] x);
        logic signed [15:0] a;
        a = x;
        for (int s = 0; s < 6; s++) begin
            a = add16(a, mulq(my1[s], mcoef[2*s]));
            a = add16(a, mulq(my2[s], mcoef[2*s+1]));
            my2[s] = my1[s];
            my1[s] = a;
        end
        return a;
    endfunction

    function automatic void model_clear();
        for (int s = 0; s < 6; s++) begin
            my1[s] = 16'sd0;
            my2[s] = 16'sd0;
        end
    endfunction

    // ---------------- multiplier model ----------------
    int          lat = 12;
    int          cnt = 0;
    int          viol = 0;
    logic [15:0] op_sig = 16'd0;
    logic [9:0]  op_coef = 10'd0;

    always @(posedge clk) begin
        mul_done <= 1'b0;
        if (cnt != 0) begin
            if (mul_sig !== op_sig || mul_coef !== op_coef) viol = viol + 1;
            if (cnt == 1) begin
                mul_done   <= 1'b1;
                mul_result <= mulq(op_sig, op_coef);
            end
            cnt = cnt - 1;
        end
        if (mul_start === 1'b1) begin
            if (cnt != 0 || state_clr) viol = viol + 1;
            cnt     = lat - 1;
            op_sig  = mul_sig;
            op_coef = mul_coef;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_ready();
        for (int i = 0; i < 3000 && !ready; i++) @(negedge clk);
        if (!ready) check("ready_timeout", ready, 1);
    endtask

    task automatic write_coef(input logic [3:0] a, input logic [9:0] d);
        @(negedge clk);
        coef_wr = 1'b1; coef_addr = a; coef_data = d;
        @(negedge clk);
        coef_wr = 1'b0;
        if (a < 12) mcoef[a] = d;
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        state_clr = 1'b1;
        @(negedge clk);
        state_clr = 1'b0;
        model_clear();
    endtask

    // Sends one sample (cycle 0 = acceptance cycle); optionally writes a coefficient in
    // cycle wr_cyc. Returns the output and the cycle its valid pulse was seen (-1: none).
    task automatic send_sample(input logic signed [15:0] x, input int wr_cyc,
                               input logic [3:0] wa, input logic [9:0] wd,
                               output logic signed [15:0] got, output int vcyc,
                               output logic signed [15:0] exp);
        wait_ready();
        exp = model_step(x);
        sample_in = x; sample_valid = 1'b1;
        vcyc = -1; got = 16'sd0;
        for (int c = 1; c < 3000 && vcyc < 0; c++) begin
            @(negedge clk);
            if (sample_out_valid) begin
                vcyc = c;
                got  = $signed(sample_out);
            end
            sample_valid = 1'b0;
            coef_wr = (c == wr_cyc); coef_addr = wa; coef_data = wd;
        end
        coef_wr = 1'b0;
        if (wr_cyc > 0 && wa < 12) mcoef[wa] = wd;
    endtask

    logic signed [15:0] got, exp;
    int vcyc;

    initial begin
        logic signed [15:0] exp_list [3];
        int saw_v, saw_d, nst, back;
        rst_an = 1'b0;
        sample_in = 16'd0; sample_valid = 1'b0; coef_wr = 1'b0; coef_addr = 4'd0;
        coef_data = 10'd0; state_clr = 1'b0;
        model_clear();
        for (int i = 0; i < 12; i++) mcoef[i] = 10'sd0;
        @(negedge clk); @(negedge clk);
        check("rst_ready", ready, 1);
        check("rst_start", mul_start, 0);
        check("rst_sig", mul_sig, 0);
        check("rst_coef", mul_coef, 0);
        check("rst_out", sample_out, 0);
        check("rst_valid", sample_out_valid, 0);
        rst_an = 1'b1;
        @(negedge clk);

        // All coefficients zero: pass-through with nominal timing.
        send_sample(16'sd1000, -1, 4'd0, 10'd0, got, vcyc, exp);
        check("pass_val", got, 1000);
        check("pass_cyc", vcyc, 163);
        @(negedge clk);
        check("pass_ready164", ready, 1);

        // b1[0] = 1.0: integrator holds the value.
        pulse_clr();
        write_coef(4'd0, 10'd256);
        for (int i = 0; i < 3; i++) begin
            send_sample((i == 0) ? 16'sd100 : 16'sd0, -1, 4'd0, 10'd0, got, vcyc, exp);
            check("integ", got, 100);
        end

        // b1[0] = 0.5: geometric decay.
        pulse_clr();
        write_coef(4'd0, 10'd128);
        exp_list[0] = 16'sd1024; exp_list[1] = 16'sd512; exp_list[2] = 16'sd256;
        for (int i = 0; i < 3; i++) begin
            send_sample((i == 0) ? 16'sd1024 : 16'sd0, -1, 4'd0, 10'd0, got, vcyc, exp);
            check("decay", got, exp_list[i]);
        end

        // Overflow handling.
        pulse_clr();
        write_coef(4'd0, 10'd256);
        send_sample(16'sd30000, -1, 4'd0, 10'd0, got, vcyc, exp);
        check("ovf_first", got, 30000);
        send_sample(16'sd30000, -1, 4'd0, 10'd0, got, vcyc, exp);
`ifdef TWOPOLE_SAT_EN
        check("ovf_second", got, 32767);
`else
        check("ovf_second", got, -5536);
`endif

        // Clear in cycle 50 (section 1, mid-multiply).
        pulse_clr();
        wait_ready();
        sample_in = 16'sd500; sample_valid = 1'b1;
        saw_v = 0; saw_d = 0; nst = 0; back = 0;
        for (int c = 1; c < 400 && back == 0; c++) begin
            @(negedge clk);
            sample_valid = 1'b0;
            state_clr = (c == 50);
            #1;
            if (c >= 50) begin
                if (sample_out_valid) saw_v = 1;
                if (saw_d == 0 && mul_start) nst++;
                if (mul_done) saw_d = 1;
                if (ready && c > 50) back = 1;
            end
        end
        state_clr = 1'b0;
        model_clear();
        check("clr_no_valid", saw_v, 0);
        check("clr_no_start", nst, 0);
        check("clr_drained", saw_d, 1);
        check("clr_idle", back, 1);
        send_sample(16'sd700, -1, 4'd0, 10'd0, got, vcyc, exp);
        check("clr_hist", got, 700);

        // Coefficient write in the section-0 ISSUE1 cycle uses the old value.
        pulse_clr();
        send_sample(16'sd300, -1, 4'd0, 10'd0, got, vcyc, exp);
        check("cw_first", got, 300);
        send_sample(16'sd0, 1, 4'd0, 10'd128, got, vcyc, exp);
        check("cw_old", got, 300);
        send_sample(16'sd0, -1, 4'd0, 10'd0, got, vcyc, exp);
        check("cw_new", got, 150);

        // Randomized coefficients, samples, latencies and occasional clears.
        for (int i = 0; i < 30; i++) begin
            lat = $urandom_range(2, 14);
            if ($urandom_range(0, 2) == 0)
                write_coef(4'($urandom_range(0, 15)), 10'($urandom_range(0, 1023)));
            if ($urandom_range(0, 7) == 0) pulse_clr();
            send_sample(16'($urandom), -1, 4'd0, 10'd0, got, vcyc, exp);
            check("rand_done", (vcyc > 0), 1);
            check("rand_val", got, exp);
        end

        check("mul_protocol", viol, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/twopole_cascade.md
# twopole_cascade

Six-section cascade of two-pole resonators forming the speech synthesis filter. It accepts one 16-bit excitation sample at a time and computes each section's feedback products with the shared 16x10 serial/parallel multiplier, acting as that multiplier's initiator over its start/done handshake. It emits one filtered sample per input and sits between the excitation source and the output DAC path.

## Interface
- NSEC, 6, number of cascaded sections; coefficient addresses 0..2*NSEC-1.
- clk  in  1  clock.
- rst_an  in  1  reset; asynchronous, active-low.
- sample_in  in  16  signed excitation sample.
- sample_valid  in  1  sample_in is valid; accepted only while ready=1.
- ready  out  1  high in IDLE only.
- coef_wr  in  1  coefficient write strobe.
- coef_addr  in  4  coefficient address: 2s is b1 of section s, 2s+1 is b2 of section s. Writes to addresses ≥12 are ignored.
- coef_data  in  10  signed coefficient value. 256 = 1.0.
- state_clr  in  1  synchronous clear of filter history and abort of the current sample.
- mul_sig  out  16  multiplier signal operand (registered).
- mul_coef  out  10  multiplier coefficient operand (registered).
- mul_start  out  1  one-cycle multiply request.
- mul_done  in  1  one-cycle multiplier completion pulse.
- mul_result  in  16  multiplier product, equal to (mul_sig*mul_coef)>>>8 truncated to 16 bits.
- sample_out  out  16  signed filtered sample (registered).
- sample_out_valid  out  1  one-cycle pulse when sample_out is updated.

## Operation
- Storage:
  - coefficient file of 12 x 10 bits;
  - history y1[s] and y2[s], 16 bits each;
  - 16-bit accumulator acc.
- Per section s: acc = x_s + b1[s]*y1[s] + b2[s]*y2[s], then y2[s] ← y1[s], y1[s] ← acc, and x_{s+1} = acc.
- x_0 = sample_in. The output is the acc value of section NSEC-1.
- FSM states: IDLE, ISSUE1, WAIT1, ISSUE2, WAIT2, UPDATE, OUTPUT, DRAIN.
  - IDLE: when sample_valid=1, latch the sample into acc, set s=0, go to ISSUE1.
  - ISSUE1: load mul_sig=y1[s] and mul_coef=b1[s], pulse mul_start, go to WAIT1.
  - WAIT1: on mul_done=1, acc ← acc + mul_result and go to ISSUE2.
  - ISSUE2 and WAIT2: same as ISSUE1/WAIT1 using y2[s] and b2[s]; on done go to UPDATE.
  - UPDATE: shift history for section s. If s=NSEC-1 go to OUTPUT; otherwise s++ and go to ISSUE1.
  - OUTPUT: sample_out ← acc, pulse sample_out_valid, go to IDLE.
- Addition: sum computed at 17 bits, reduced to 16 bits per the configuration section.
- Coefficient writes are accepted in any state and land at the clock edge. A multiply issued in the same cycle as a write to its coefficient uses the old value.
- mul_done is ignored in IDLE, ISSUE1, ISSUE2, UPDATE and OUTPUT.
- A busy flag is set when mul_start is pulsed and cleared on mul_done.
- state_clr in any state:
  - zeroes all y1/y2 and suppresses any output for the current sample;
  - if busy, goes to DRAIN, which waits for mul_done and then goes to IDLE; otherwise goes directly to IDLE.
  - mul_start is never asserted in the cycle state_clr is high or while in DRAIN.
  - state_clr has priority over sample_valid.
- Reset values:
  - ready=1; mul_start=0, mul_sig=0, mul_coef=0;
  - sample_out=0, sample_out_valid=0;
  - all coefficients and history registers = 0; FSM in IDLE.

## Timing
- The block is latency-agnostic: each WAIT state holds until mul_done arrives.
- With the standard multiplier, mul_done arrives 12 cycles after the mul_start cycle.
- Sample accepted at cycle 0 gives these cycles:
  - ISSUE1 of section 0: cycle 1.
  - Each multiply: 13 cycles. Each section: 27 cycles.
  - Final UPDATE: cycle 162.
  - sample_out_valid: high in cycle 163.
  - ready: high again in cycle 164.
- Throughput: one sample per 164 cycles.
- mul_sig and mul_coef hold stable from the ISSUE cycle until mul_done.
- At most one multiply is outstanding at any time.

## Configuration
- TWOPOLE_SAT_EN defined: each 17-bit sum is clamped to the range [-32768, 32767].
- TWOPOLE_SAT_EN undefined: each sum wraps modulo 2^16 (low 16 bits kept).

## Test plan
- All coefficients 0, sample 1000 at cycle 0 → sample_out=1000, valid in cycle 163, ready high in cycle 164.
- Section 0 b1=256, others 0; samples 100, 0, 0 → outputs 100, 100, 100.
- Section 0 b1=128 only; samples 1024, 0, 0 → outputs 1024, 512, 256.
- Section 0 b1=256 only; samples 30000, 30000 → second output 32767 with TWOPOLE_SAT_EN, -5536 without.
- state_clr in cycle 50 (mid-WAIT):
  - → no sample_out_valid for that sample;
  - mul_start stays low until the pending mul_done;
  - next sample with b1=256 outputs an unchanged value (history cleared).
- coef_wr to addr 0 in the same cycle as section-0 ISSUE1 → old b1 used; the new value applies to the next sample.
